// File: rtl/sds_pkg.sv
// ---------------------------------------------------------------------------
// sds_pkg
// Shared types and constants for the scalable_data_structure packet FIFO.
//   packet_t : one stored packet {id, src, dest, payload}
//   *_DEFAULT: pointer/count widths for the default depth
// Optional feature macro used by the top level: SDS_ERR_FLAGS_EN
// ---------------------------------------------------------------------------
package sds_pkg;

  localparam int DEPTH_DEFAULT = 1024;
  localparam int ID_W          = 32;
  localparam int DATA_W        = 128;

  typedef struct packed {
    int                id;
    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] dest;
    logic [DATA_W-1:0] payload;
  } packet_t;

  localparam int PKT_W         = $bits(packet_t);
  localparam int PTR_W_DEFAULT = $clog2(DEPTH_DEFAULT);
  localparam int CNT_W_DEFAULT = PTR_W_DEFAULT + 1;

endpackage : sds_pkg

// File: rtl/sds_mem.sv
// ---------------------------------------------------------------------------
// sds_mem
// DEPTH x W simple dual-port storage: one synchronous write port and one
// synchronous read port. The read register is only loaded when re is high,
// so rd_data holds the last read word otherwise. Read-before-write when both
// ports address the same entry in one cycle (old contents are returned).
// Ports:
//   clk            : clock
//   we/waddr/wdata : write port
//   re/raddr       : read enable and address
//   rd_data        : registered read data
// ---------------------------------------------------------------------------
module sds_mem #(
  parameter int DEPTH = 1024,
  parameter int W     = 416,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_data_q;

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_data_q <= mem[raddr];
  end

  assign rd_data = rd_data_q;

endmodule : sds_mem

// File: rtl/scalable_data_structure.sv
// ---------------------------------------------------------------------------
// scalable_data_structure
// Synchronous packet FIFO with registered read data (1-cycle pop latency).
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   push, id/src/dest/payload : write request and packet
//   pop                     : read request for the head packet
//   empty, full             : status from the registered count
//   out_id/src/dest/payload : last popped packet (0 after reset)
//   overflow, underflow     : sticky error flags, only when the macro
//                             SDS_ERR_FLAGS_EN is defined
// ---------------------------------------------------------------------------
module scalable_data_structure
  import sds_pkg::*;
#(
  parameter int DEPTH  = sds_pkg::DEPTH_DEFAULT,
  parameter int ID_W   = sds_pkg::ID_W,
  parameter int DATA_W = sds_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  int                id,
  input  logic [DATA_W-1:0] src,
  input  logic [DATA_W-1:0] dest,
  input  logic [DATA_W-1:0] payload,
  output logic              empty,
  output logic              full,
`ifdef SDS_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output int                out_id,
  output logic [DATA_W-1:0] out_src,
  output logic [DATA_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_payload
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int MEM_W = ID_W + 3 * DATA_W;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  // Marks that at least one pop has landed since reset; until then the
  // read register contents are meaningless and the outputs show zero.
  logic             out_vld_q, out_vld_d;

  logic             push_ok;
  logic             pop_ok;
  logic [MEM_W-1:0] wr_word;
  logic [MEM_W-1:0] rd_word;
  packet_t          wr_pkt;
  packet_t          rd_pkt;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A full FIFO can still take a push when a pop frees the head slot in the
  // same cycle (full implies non-empty, so that pop is always accepted).
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  assign wr_pkt  = '{id: id, src: src, dest: dest, payload: payload};
  assign wr_word = wr_pkt;
  assign rd_pkt  = rd_word;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    out_vld_d = out_vld_q | pop_ok;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      out_vld_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
    end
  end

  // The RAM read register doubles as the output register; it only loads
  // on an accepted pop, which gives the hold behaviour on idle cycles.
  sds_mem #(
    .DEPTH (DEPTH),
    .W     (MEM_W),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we      (push_ok),
    .waddr   (wptr_q),
    .wdata   (wr_word),
    .re      (pop_ok),
    .raddr   (rptr_q),
    .rd_data (rd_word)
  );

  assign out_id      = out_vld_q ? rd_pkt.id      : '0;
  assign out_src     = out_vld_q ? rd_pkt.src     : '0;
  assign out_dest    = out_vld_q ? rd_pkt.dest    : '0;
  assign out_payload = out_vld_q ? rd_pkt.payload : '0;

`ifdef SDS_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (push && !push_ok);
    unf_d = unf_q | (pop && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule : scalable_data_structure

// File: tb/tb_scalable_data_structure.sv
// ---------------------------------------------------------------------------
// tb_scalable_data_structure
// Self-checking bench for the packet FIFO. A queue-based reference model
// tracks the expected contents, last popped packet and error flags.
// Build with +define+SDS_ERR_FLAGS_EN to exercise the error flags.
// ---------------------------------------------------------------------------
module tb_scalable_data_structure;
  import sds_pkg::*;

  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  int           id = 0;
  logic [127:0] src = '0;
  logic [127:0] dest = '0;
  logic [127:0] payload = '0;
  logic         empty, full;
  int           out_id;
  logic [127:0] out_src, out_dest, out_payload;
`ifdef SDS_ERR_FLAGS_EN
  logic         overflow, underflow;
`endif

  always #5 clk = ~clk;

  scalable_data_structure #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .pop         (pop),
    .id          (id),
    .src         (src),
    .dest        (dest),
    .payload     (payload),
    .empty       (empty),
    .full        (full),
`ifdef SDS_ERR_FLAGS_EN
    .overflow    (overflow),
    .underflow   (underflow),
`endif
    .out_id      (out_id),
    .out_src     (out_src),
    .out_dest    (out_dest),
    .out_payload (out_payload)
  );

  // Reference model
  packet_t mq[$];
  packet_t m_out;
  bit      m_ovf, m_unf;
  int      checks = 0;
  int      failures = 0;
  int      txn = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  function automatic packet_t mk(input int i, input logic [127:0] s, input logic [127:0] d,
                                 input logic [127:0] p);
    packet_t r;
    r.id = i; r.src = s; r.dest = d; r.payload = p;
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_out = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_state();
    check_eq("empty", empty, mq.size() == 0);
    check_eq("full", full, mq.size() == DEPTH);
    check_eq("out_id", out_id, m_out.id);
    check_eq("out_src", out_src, m_out.src);
    check_eq("out_dest", out_dest, m_out.dest);
    check_eq("out_payload", out_payload, m_out.payload);
`ifdef SDS_ERR_FLAGS_EN
    check_eq("overflow", overflow, m_ovf);
    check_eq("underflow", underflow, m_unf);
`endif
  endtask

  // One clock of stimulus: drive, advance the model, check after the edge.
  task automatic step(input bit p, input bit q, input packet_t pk);
    bit pop_ok, push_ok;
    @(negedge clk);
    push = p; pop = q;
    id = pk.id; src = pk.src; dest = pk.dest; payload = pk.payload;
    pop_ok  = q && mq.size() > 0;
    push_ok = p && (mq.size() < DEPTH || q);
    if (p && !push_ok) m_ovf = 1'b1;
    if (q && mq.size() == 0) m_unf = 1'b1;
    if (pop_ok) m_out = mq.pop_front();
    if (push_ok) mq.push_back(pk);
    @(posedge clk);
    #1;
    txn++;
    check_state();
    $display("txn %0d push=%0b pop=%0b id=%0d out_id=%0d size=%0d",
             txn, p, q, pk.id, out_id, mq.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    push = 1'b0; pop = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_state();
    rst_n = 1'b1;
  endtask

  packet_t nop;
  int      k;

  initial begin
    model_clear();
    nop = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Ordering: 1000 pushes then 1000 pops
    for (int i = 0; i < 1000; i++)
      step(1'b1, 1'b0, mk(i, 128'(i % 100), 128'((i + 1) % 10), rnd128()));
    for (k = 0; k < 1000; k++) begin
      step(1'b0, 1'b1, nop);
      check_eq("ord_id", out_id, k);
      check_eq("ord_src", out_src, 128'(k % 100));
      check_eq("ord_dest", out_dest, 128'((k + 1) % 10));
    end
    check_eq("ord_empty_end", empty, 1'b1);

    // Full boundary: 1025 pushes, the last one is dropped
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, mk(i, rnd128(), rnd128(), rnd128()));
      if (i == DEPTH - 1) check_eq("full_at_depth", full, 1'b1);
    end
`ifdef SDS_ERR_FLAGS_EN
    check_eq("ovf_after_drop", overflow, 1'b1);
`endif
    for (k = 0; k < DEPTH; k++) begin
      step(1'b0, 1'b1, nop);
      check_eq("full_pop_id", out_id, k);
    end
    check_eq("full_drained", empty, 1'b1);

    // Empty pop holds the previous output
    do_reset();
    step(1'b1, 1'b0, mk(5, 128'h5, 128'h55, 128'h555));
    step(1'b0, 1'b1, nop);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, nop);
      check_eq("epop_out_id", out_id, 5);
      check_eq("epop_empty", empty, 1'b1);
    end
`ifdef SDS_ERR_FLAGS_EN
    check_eq("unf_set", underflow, 1'b1);
`endif

    // Simultaneous push and pop
    do_reset();
    step(1'b1, 1'b0, mk(10, rnd128(), rnd128(), rnd128()));
    step(1'b1, 1'b0, mk(11, rnd128(), rnd128(), rnd128()));
    step(1'b1, 1'b1, mk(12, rnd128(), rnd128(), rnd128()));
    check_eq("sim_out_id", out_id, 10);
    step(1'b0, 1'b1, nop);
    check_eq("sim_pop11", out_id, 11);
    step(1'b0, 1'b1, nop);
    check_eq("sim_pop12", out_id, 12);
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b0, mk(100 + i, rnd128(), rnd128(), rnd128()));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, mk(5000 + i, rnd128(), rnd128(), rnd128()));
      check_eq("sim_full_hold", full, 1'b1);
      check_eq("sim_full_out", out_id, 100 + i);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, nop);
    check_eq("sim_last_id", out_id, 5003);

    // Reset mid-stream, asserted between clock edges
    do_reset();
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, mk(i, rnd128(), rnd128(), rnd128()));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, nop);
    @(posedge clk);
    #3;
    push = 1'b0; pop = 1'b0;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_eq("mid_rst_empty", empty, 1'b1);
    check_eq("mid_rst_out_id", out_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, mk(99, rnd128(), rnd128(), rnd128()));
    step(1'b0, 1'b1, nop);
    check_eq("mid_rst_99", out_id, 99);

    // Randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 500) % 2 == 0) ? 75 : 35;
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) < 55,
           mk(int'($urandom), rnd128(), rnd128(), rnd128()));
    end

    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_scalable_data_structure
